// File: rtl/parity_lane_monitor.sv
`default_nettype none
// ============================================================================
// parity_lane_monitor : windowed per-lane counter with sticky threshold alarms
// Revision: 1.0
// ============================================================================
module parity_lane_monitor #(
  parameter int CNT_W  = 8,
  parameter int WINDOW = 16,
  parameter int THRESH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic             valid_i,
  input  logic [2:0]       par_i,
  input  logic             clear_i,
  output logic [CNT_W-1:0] cnt0_o,
  output logic [CNT_W-1:0] cnt1_o,
  output logic [CNT_W-1:0] cnt2_o,
  output logic             win_done_o,
  output logic [2:0]       alarm_o,
  output logic             busy_o
);

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] SAMP_LAST = CNT_W'(WINDOW - 1);
  localparam logic [CNT_W-1:0] THRESH_V  = CNT_W'(THRESH);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] samp_q, samp_d;
  logic [CNT_W-1:0] acc_q [3];
  logic [CNT_W-1:0] acc_d [3];
  logic [CNT_W-1:0] cnt_q [3];
  logic [CNT_W-1:0] cnt_d [3];
  logic [CNT_W-1:0] final_v [3];
  logic             win_done_q, win_done_d;
  logic [2:0]       alarm_q, alarm_d;
  logic             busy_q, busy_d;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] a, input logic b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{CNT_W{1'b0}}, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  always_comb begin
    state_d    = state_q;
    samp_d     = samp_q;
    win_done_d = 1'b0;
    alarm_d    = alarm_q;
    for (int k = 0; k < 3; k++) begin
      acc_d[k]   = acc_q[k];
      cnt_d[k]   = cnt_q[k];
      final_v[k] = sat_inc(acc_q[k], par_i[k]);
    end

    case (state_q)
      IDLE:    if (enable_i)  state_d = COUNT;
      COUNT:   if (!enable_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Clear beats a coincident window end; an abort discards the partial window.
    if (clear_i) begin
      samp_d  = '0;
      alarm_d = '0;
      for (int k = 0; k < 3; k++) begin
        acc_d[k] = '0;
        cnt_d[k] = '0;
      end
    end else if (state_q == COUNT && !enable_i) begin
      samp_d = '0;
      for (int k = 0; k < 3; k++) acc_d[k] = '0;
    end else if (state_q == COUNT && valid_i) begin
      if (samp_q == SAMP_LAST) begin
        samp_d     = '0;
        win_done_d = 1'b1;
        for (int k = 0; k < 3; k++) begin
          acc_d[k]   = '0;
          cnt_d[k]   = final_v[k];
          alarm_d[k] = alarm_q[k] | (final_v[k] >= THRESH_V);
        end
      end else begin
        samp_d = samp_q + CNT_W'(1);
        for (int k = 0; k < 3; k++) acc_d[k] = final_v[k];
      end
    end

    busy_d = (state_d == COUNT);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      samp_q     <= '0;
      win_done_q <= 1'b0;
      alarm_q    <= '0;
      busy_q     <= 1'b0;
      for (int k = 0; k < 3; k++) begin
        acc_q[k] <= '0;
        cnt_q[k] <= '0;
      end
    end else begin
      state_q    <= state_d;
      samp_q     <= samp_d;
      win_done_q <= win_done_d;
      alarm_q    <= alarm_d;
      busy_q     <= busy_d;
      for (int k = 0; k < 3; k++) begin
        acc_q[k] <= acc_d[k];
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign cnt0_o     = cnt_q[0];
  assign cnt1_o     = cnt_q[1];
  assign cnt2_o     = cnt_q[2];
  assign win_done_o = win_done_q;
  assign alarm_o    = alarm_q;
  assign busy_o     = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_parity_lane_monitor.sv
`default_nettype none
// ============================================================================
// tb_parity_lane_monitor : directed bench for parity_lane_monitor
// Revision: 1.0
// ============================================================================
module tb_parity_lane_monitor;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable_i, valid_i, clear_i;
  logic [2:0] par_i;
  logic [7:0] cnt0_o, cnt1_o, cnt2_o;
  logic       win_done_o, busy_o;
  logic [2:0] alarm_o;

  logic       s_enable_i, s_valid_i, s_clear_i;
  logic [2:0] s_par_i;
  logic [3:0] s_cnt0_o, s_cnt1_o, s_cnt2_o;
  logic       s_win_done_o, s_busy_o;
  logic [2:0] s_alarm_o;

  int checks = 0;
  int passes = 0;

  always #5 clk = ~clk;

  parity_lane_monitor #(.CNT_W(8), .WINDOW(16), .THRESH(4)) dut (
    .clk(clk), .rst(rst), .enable_i(enable_i), .valid_i(valid_i), .par_i(par_i),
    .clear_i(clear_i), .cnt0_o(cnt0_o), .cnt1_o(cnt1_o), .cnt2_o(cnt2_o),
    .win_done_o(win_done_o), .alarm_o(alarm_o), .busy_o(busy_o)
  );

  parity_lane_monitor #(.CNT_W(4), .WINDOW(16), .THRESH(4)) dut_sat (
    .clk(clk), .rst(rst), .enable_i(s_enable_i), .valid_i(s_valid_i), .par_i(s_par_i),
    .clear_i(s_clear_i), .cnt0_o(s_cnt0_o), .cnt1_o(s_cnt1_o), .cnt2_o(s_cnt2_o),
    .win_done_o(s_win_done_o), .alarm_o(s_alarm_o), .busy_o(s_busy_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic send(input logic [2:0] p);
    valid_i = 1'b1;
    par_i   = p;
    tick();
    valid_i = 1'b0;
    par_i   = 3'b000;
  endtask

  task automatic s_send(input logic [2:0] p);
    s_valid_i = 1'b1;
    s_par_i   = p;
    tick();
    s_valid_i = 1'b0;
  endtask

  initial begin
    rst = 1'b1; enable_i = 1'b1; valid_i = 1'b1; par_i = 3'b111; clear_i = 1'b0;
    s_enable_i = 1'b0; s_valid_i = 1'b0; s_par_i = 3'b000; s_clear_i = 1'b0;

    // Reset with enable and valid asserted
    tick();
    tick();
    check("rst_cnt0", cnt0_o, 0);
    check("rst_cnt1", cnt1_o, 0);
    check("rst_cnt2", cnt2_o, 0);
    check("rst_win_done", win_done_o, 0);
    check("rst_alarm", alarm_o, 0);
    check("rst_busy", busy_o, 0);

    // First cycle after release is IDLE; the valid sample here must be ignored
    rst = 1'b0;
    check("idle_busy", busy_o, 0);
    tick();
    valid_i = 1'b0;
    check("count_busy", busy_o, 1);

    // Basic window: 5 x 101 then 11 x 000
    for (int i = 0; i < 5; i++) send(3'b101);
    for (int i = 0; i < 10; i++) send(3'b000);
    check("basic_no_early_done", win_done_o, 0);
    send(3'b000);
    check("basic_done", win_done_o, 1);
    check("basic_cnt0", cnt0_o, 5);
    check("basic_cnt1", cnt1_o, 0);
    check("basic_cnt2", cnt2_o, 5);
    check("basic_alarm", alarm_o, 3'b101);
    tick();
    check("basic_done_pulse", win_done_o, 0);

    // Gapped window of 16 x 010
    for (int i = 0; i < 15; i++) begin
      send(3'b010);
      tick();
    end
    send(3'b010);
    check("gap_done", win_done_o, 1);
    check("gap_cnt1", cnt1_o, 16);
    check("gap_cnt0", cnt0_o, 0);
    check("gap_alarm", alarm_o, 3'b111);

    // Sample issued during the publish cycle starts window 2
    send(3'b010);
    check("b2b_done_low", win_done_o, 0);
    for (int i = 0; i < 14; i++) send(3'b000);
    check("b2b_no_early_done", win_done_o, 0);
    send(3'b000);
    check("b2b_done", win_done_o, 1);
    check("b2b_cnt1", cnt1_o, 1);
    check("b2b_alarm", alarm_o, 3'b111);

    // Clear coincident with the 16th sample
    for (int i = 0; i < 15; i++) send(3'b111);
    clear_i = 1'b1;
    send(3'b111);
    clear_i = 1'b0;
    check("clr_done", win_done_o, 0);
    check("clr_cnt0", cnt0_o, 0);
    check("clr_cnt1", cnt1_o, 0);
    check("clr_cnt2", cnt2_o, 0);
    check("clr_alarm", alarm_o, 0);
    for (int i = 0; i < 4; i++) send(3'b010);
    for (int i = 0; i < 11; i++) send(3'b000);
    check("clr_no_early_done", win_done_o, 0);
    send(3'b000);
    check("clr_new_done", win_done_o, 1);
    check("clr_new_cnt1", cnt1_o, 4);
    check("clr_new_alarm", alarm_o, 3'b010);

    // Abort after 10 samples, then a fresh all-zero window
    for (int i = 0; i < 10; i++) send(3'b001);
    enable_i = 1'b0;
    tick();
    check("abort_busy", busy_o, 0);
    check("abort_cnt1_hold", cnt1_o, 4);
    tick();
    enable_i = 1'b1;
    tick();
    check("reenable_busy", busy_o, 1);
    for (int i = 0; i < 15; i++) send(3'b000);
    check("abort_no_early_done", win_done_o, 0);
    send(3'b000);
    check("abort_done", win_done_o, 1);
    check("abort_cnt0", cnt0_o, 0);
    check("abort_alarm", alarm_o, 3'b010);

    // Saturation with a 4-bit counter
    s_enable_i = 1'b1;
    tick();
    for (int i = 0; i < 16; i++) s_send(3'b111);
    check("sat_done", s_win_done_o, 1);
    check("sat_cnt0", s_cnt0_o, 15);
    check("sat_cnt1", s_cnt1_o, 15);
    check("sat_cnt2", s_cnt2_o, 15);
    check("sat_alarm", s_alarm_o, 3'b111);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
`default_nettype wire
